div_share_ctrl: RTL and testbench

- Round-robin controller that shares one pipelined div_u39_u31 divider instance between NUM_REQ requesters.
- Accepts one divide per enabled cycle and drives the divider operands and clock enable.
- Carries requester ID and a divide-by-zero flag down a tag pipeline matched to divider latency, then returns each result with its ID.
- Sits between demo/system logic and the divider core.

---
 rtl/div_share_pkg.sv | 32 +++
 rtl/div_tag_pipe.sv | 38 +++
 rtl/div_share_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// ---------------------------------------------------------------------------
// div_share_pkg
// Shared types and helpers for the div_u39_u31 sharing controller.
//   DEF_DIVIDEND_W / DEF_DIVISOR_W : default operand widths of the divider core
//   TAG_ID_W                       : requester ID width carried in the tag
//                                    (sized for the 8-requester maximum)
//   div_tag_t                      : per-operation tag travelling beside the
//                                    divider pipeline
//   rr_next()                      : round-robin pointer advance with wrap
// ---------------------------------------------------------------------------
package div_share_pkg;

  localparam int DEF_DIVIDEND_W = 39;
  localparam int DEF_DIVISOR_W  = 31;
  localparam int MAX_REQ        = 8;
  localparam int TAG_ID_W       = 3;

  // dividend_lo is only meaningful when dz is set: it becomes the remainder.
  typedef struct packed {
    logic                     valid;
    logic [TAG_ID_W-1:0]      id;
    logic                     dz;
    logic [DEF_DIVISOR_W-1:0] dividend_lo;
  } div_tag_t;

  // Pointer to the requester after 'id', wrapping at num_req.
  function automatic logic [TAG_ID_W-1:0] rr_next(input logic [TAG_ID_W-1:0] id,
                                                   input int                  num_req);
    return (int'(id) >= num_req - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// ---------------------------------------------------------------------------
// div_tag_pipe
// Enable-gated shift register of DEPTH stages used to carry operation tags
// alongside the divider pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance all stages by one when high, hold otherwise
//   din        : value entering stage 0
//   dout       : value leaving the final stage
// ---------------------------------------------------------------------------
module div_tag_pipe #(
  parameter int W     = 35,
  parameter int DEPTH = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose: the valid bits inside every stage
      // must clear so no stale operation emerges after reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, so the loop order does not matter and the shift is exact.
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/div_share_ctrl.sv
// ---------------------------------------------------------------------------
// div_share_ctrl
// Round-robin sharing of one pipelined unsigned divider between NUM_REQ
// requesters. One operation is issued per enabled cycle; a tag pipeline of
// DIV_LATENCY stages carries the requester ID and divide-by-zero flag so each
// result is returned with its owner.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clken             : global enable; low freezes issue, tags and divider
//   req_valid_i       : per-requester request
//   req_dividend_i    : flattened dividends, requester i at slice i
//   req_divisor_i     : flattened divisors, requester i at slice i
//   req_ready_o       : one-hot combinational grant
//   div_dividend_o    : registered dividend to the divider
//   div_divisor_o     : registered divisor to the divider
//   div_clken_o       : divider clock enable (clken passthrough)
//   div_quotient_i    : divider quotient
//   div_remain_i      : divider remainder
//   rsp_valid_o       : one-cycle result strobe
//   rsp_id_o          : owning requester
//   rsp_quotient_o    : quotient (all ones on divide-by-zero)
//   rsp_remain_o      : remainder (low dividend bits on divide-by-zero)
//   rsp_dz_o          : divide-by-zero flag
//   inflight_o        : operations issued and not yet returned
// Timing: the operand register is the first of the DIV_LATENCY stages, so the
// divider core behind it contributes DIV_LATENCY-1 enabled cycles and a result
// is presented on rsp_* DIV_LATENCY enabled edges after the accepting edge.
// ---------------------------------------------------------------------------
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIVIDEND_W  = DEF_DIVIDEND_W,
  parameter int DIVISOR_W   = DEF_DIVISOR_W,
  parameter int DIV_LATENCY = 40,
  parameter int ID_W        = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clken,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*DIVIDEND_W-1:0]     req_dividend_i,
  input  logic [NUM_REQ*DIVISOR_W-1:0]      req_divisor_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [DIVIDEND_W-1:0]             div_dividend_o,
  output logic [DIVISOR_W-1:0]              div_divisor_o,
  output logic                              div_clken_o,
  input  logic [DIVIDEND_W-1:0]             div_quotient_i,
  input  logic [DIVISOR_W-1:0]              div_remain_i,
  output logic                              rsp_valid_o,
  output logic [ID_W-1:0]                   rsp_id_o,
  output logic [DIVIDEND_W-1:0]             rsp_quotient_o,
  output logic [DIVISOR_W-1:0]              rsp_remain_o,
  output logic                              rsp_dz_o,
  output logic [$clog2(DIV_LATENCY+1)-1:0]  inflight_o
);

  logic [TAG_ID_W-1:0]   rr_ptr;
  logic [TAG_ID_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    upper;
  logic                  xfer;
  logic [DIVIDEND_W-1:0] sel_dividend;
  logic [DIVISOR_W-1:0]  sel_divisor;
  div_tag_t              tag_in;
  div_tag_t              tag_out;
  logic                  rsp_fire;

  assign div_clken_o = clken;

  // Round-robin pick: prefer the lowest requester at or above the pointer,
  // otherwise wrap to the lowest requester overall.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    grant        = '0;
    upper        = '0;
    gnt_id       = '0;
    xfer         = 1'b0;
    sel_dividend = '0;
    sel_divisor  = '0;
    if (clken) begin
      for (int i = 0; i < NUM_REQ; i++)
        upper[i] = req_valid_i[i] && (i >= int'(rr_ptr));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!xfer && upper[i]) begin
          grant[i] = 1'b1;
          gnt_id   = TAG_ID_W'(i);
          xfer     = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!xfer && req_valid_i[i]) begin
          grant[i] = 1'b1;
          gnt_id   = TAG_ID_W'(i);
          xfer     = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          sel_dividend = req_dividend_i[i*DIVIDEND_W +: DIVIDEND_W];
          sel_divisor  = req_divisor_i[i*DIVISOR_W +: DIVISOR_W];
        end
      end
    end
  end

  assign req_ready_o = grant;

  // A bubble (valid = 0) enters the tag pipe on every enabled cycle without
  // a transfer, keeping tags aligned with the divider's data.
  always_comb begin
    tag_in             = '0;
    tag_in.valid       = xfer;
    tag_in.id          = gnt_id;
    tag_in.dz          = (sel_divisor == '0);
    tag_in.dividend_lo = DEF_DIVISOR_W'(sel_dividend[DIVISOR_W-1:0]);
  end

  div_tag_pipe #(
    .W     ($bits(div_tag_t)),
    .DEPTH (DIV_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clken),
    .din   (tag_in),
    .dout  (tag_out)
  );

  assign rsp_fire = clken && tag_out.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_id_o       <= '0;
      rsp_quotient_o <= '0;
      rsp_remain_o   <= '0;
      rsp_dz_o       <= 1'b0;
      inflight_o     <= '0;
    end else begin
      // Cleared while clken is low so a stall never stretches the strobe.
      rsp_valid_o <= rsp_fire;

      if (xfer) begin
        div_dividend_o <= sel_dividend;
        div_divisor_o  <= sel_divisor;
        rr_ptr         <= rr_next(gnt_id, NUM_REQ);
      end

      if (rsp_fire) begin
        rsp_id_o       <= tag_out.id[ID_W-1:0];
        rsp_dz_o       <= tag_out.dz;
        rsp_quotient_o <= tag_out.dz ? '1 : div_quotient_i;
        rsp_remain_o   <= tag_out.dz ? DIVISOR_W'(tag_out.dividend_lo) : div_remain_i;
      end

      case ({xfer, rsp_fire})
        2'b10:   inflight_o <= inflight_o + 1'b1;
        2'b01:   inflight_o <= inflight_o - 1'b1;
        default: inflight_o <= inflight_o;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_share_ctrl
// Directed bench for div_share_ctrl with a behavioural divider core of
// DIV_LATENCY-1 enabled stages behind the controller's operand register.
// ---------------------------------------------------------------------------
module tb_div_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int AW      = 39;
  localparam int BW      = 31;
  localparam int LAT     = 40;
  localparam int IDW     = 2;
  localparam int CW      = $clog2(LAT+1);

  logic                    clk;
  logic                    rst_n;
  logic                    clken;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ*AW-1:0]   req_dividend_i;
  logic [NUM_REQ*BW-1:0]   req_divisor_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [AW-1:0]           div_dividend_o;
  logic [BW-1:0]           div_divisor_o;
  logic                    div_clken_o;
  logic [AW-1:0]           div_quotient_i;
  logic [BW-1:0]           div_remain_i;
  logic                    rsp_valid_o;
  logic [IDW-1:0]          rsp_id_o;
  logic [AW-1:0]           rsp_quotient_o;
  logic [BW-1:0]           rsp_remain_o;
  logic                    rsp_dz_o;
  logic [CW-1:0]           inflight_o;

  div_share_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .DIVIDEND_W  (AW),
    .DIVISOR_W   (BW),
    .DIV_LATENCY (LAT),
    .ID_W        (IDW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clken          (clken),
    .req_valid_i    (req_valid_i),
    .req_dividend_i (req_dividend_i),
    .req_divisor_i  (req_divisor_i),
    .req_ready_o    (req_ready_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_clken_o    (div_clken_o),
    .div_quotient_i (div_quotient_i),
    .div_remain_i   (div_remain_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_id_o       (rsp_id_o),
    .rsp_quotient_o (rsp_quotient_o),
    .rsp_remain_o   (rsp_remain_o),
    .rsp_dz_o       (rsp_dz_o),
    .inflight_o     (inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider core. On divide-by-zero it emits a junk pattern so
  // the controller's forcing of quotient/remainder is visible.
  logic [AW-1:0] q_pipe [LAT-1];
  logic [BW-1:0] r_pipe [LAT-1];

  initial begin
    for (int i = 0; i < LAT-1; i++) begin
      q_pipe[i] = '0;
      r_pipe[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (div_clken_o) begin
      if (div_divisor_o == '0) begin
        q_pipe[0] <= 39'h15_5555_5555;
        r_pipe[0] <= 31'h2AAA_AAAA;
      end else begin
        q_pipe[0] <= div_dividend_o / AW'(div_divisor_o);
        r_pipe[0] <= BW'(div_dividend_o % AW'(div_divisor_o));
      end
      for (int i = 1; i < LAT-1; i++) begin
        q_pipe[i] <= q_pipe[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign div_quotient_i = q_pipe[LAT-2];
  assign div_remain_i   = r_pipe[LAT-2];

  // Expected responses in issue order.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  q;
    logic [BW-1:0]  r;
    logic           dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rsp_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_lit(input int id, input logic [AW-1:0] q,
                                  input logic [BW-1:0] r, input logic dz);
    exp_t e;
    e.id = IDW'(id);
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    return e;
  endfunction

  function automatic exp_t mk_exp(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b);
    if (b == '0) return mk_lit(id, '1, a[BW-1:0], 1'b1);
    return mk_lit(id, a / AW'(b), BW'(a % AW'(b)), 1'b0);
  endfunction

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_dividend_i[idx*AW +: AW] = a;
    req_divisor_i[idx*BW +: BW]  = b;
  endtask

  // Response monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id_o), 64'(e.id));
        check("rsp_q",  64'(rsp_quotient_o), 64'(e.q));
        check("rsp_r",  64'(rsp_remain_o), 64'(e.r));
        check("rsp_dz", 64'(rsp_dz_o), 64'(e.dz));
      end
    end
  end

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((inflight_o != '0 || exp_q.size() != 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(cyc < 300), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   base;
    int   stall_rsp;
    int   mptr;
    logic [AW-1:0] ta [4];
    logic [BW-1:0] tb [4];
    logic [AW-1:0] tq [4];
    logic [BW-1:0] tr [4];

    rst_n          = 1'b0;
    clken          = 1'b1;
    req_valid_i    = '0;
    req_dividend_i = '0;
    req_divisor_i  = '0;

    // ---- reset state
    #1;
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_inflight",  64'(inflight_o), 64'd0);
    check("reset_div_a",     64'(div_dividend_o), 64'd0);
    check("reset_rsp_q",     64'(rsp_quotient_o), 64'd0);
    check("reset_ready",     64'(req_ready_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- single request 8/4 from requester 0, exact latency
    @(negedge clk);
    set_req(0, 39'd8, 31'd4);
    req_valid_i = 4'b0001;
    exp_q.push_back(mk_lit(0, 39'd2, 31'd0, 1'b0));
    #1 check("single_grant", 64'(req_ready_o), 64'b0001);
    @(negedge clk);
    req_valid_i = '0;
    check("single_div_a",     64'(div_dividend_o), 64'd8);
    check("single_div_b",     64'(div_divisor_o), 64'd4);
    check("single_inflight1", 64'(inflight_o), 64'd1);
    cyc = 0;
    while (!rsp_valid_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("single_latency", 64'(cyc), 64'd40);
    @(negedge clk);
    check("single_pulse_one_cycle", 64'(rsp_valid_o), 64'd0);
    check("single_inflight0", 64'(inflight_o), 64'd0);

    // ---- round robin with all requesters active (pointer reset to 0)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ta = '{39'd100, 39'd1000, 39'd12345, 39'd7};
    tb = '{31'd7,   31'd33,   31'd100,   31'd9};
    tq = '{39'd14,  39'd30,   39'd123,   39'd0};
    tr = '{31'd2,   31'd10,   31'd45,    31'd7};
    for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i]);
    req_valid_i = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      #1 check($sformatf("rr_grant_%0d", g), 64'(req_ready_o), 64'(4'b0001 << (g % 4)));
      exp_q.push_back(mk_lit(g % 4, tq[g % 4], tr[g % 4], 1'b0));
      @(negedge clk);
    end
    req_valid_i = '0;
    drain("rr_drain");

    // ---- divide by zero from requester 2
    set_req(2, 39'h12_3456_789A, 31'd0);
    req_valid_i = 4'b0100;
    #1 check("dz_grant", 64'(req_ready_o), 64'b0100);
    exp_q.push_back(mk_lit(2, 39'h7F_FFFF_FFFF, 31'h3456_789A, 1'b1));
    @(negedge clk);
    req_valid_i = '0;
    drain("dz_drain");

    // ---- clken stall with 10 operations in flight
    for (int k = 0; k < 10; k++) begin
      set_req(3, AW'(1000 + 37*k), BW'(3 + k));
      req_valid_i = 4'b1000;
      exp_q.push_back(mk_exp(3, AW'(1000 + 37*k), BW'(3 + k)));
      @(negedge clk);
    end
    req_valid_i = '0;
    repeat (10) @(negedge clk);
    check("stall_inflight_before", 64'(inflight_o), 64'd10);
    clken       = 1'b0;
    req_valid_i = 4'b0010;
    #1 check("stall_no_grant", 64'(req_ready_o), 64'd0);
    check("stall_div_clken", 64'(div_clken_o), 64'd0);
    stall_rsp = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid_o) stall_rsp++;
    end
    check("stall_no_rsp", 64'(stall_rsp), 64'd0);
    check("stall_inflight_hold", 64'(inflight_o), 64'd10);
    req_valid_i = '0;
    clken       = 1'b1;
    base        = rsp_seen;
    drain("stall_drain");
    check("stall_rsp_count", 64'(rsp_seen - base), 64'd10);

    // ---- reset with 5 operations in flight
    for (int k = 0; k < 5; k++) begin
      set_req(1, AW'(500 + k), BW'(7));
      req_valid_i = 4'b0010;
      exp_q.push_back(mk_exp(1, AW'(500 + k), BW'(7)));
      @(negedge clk);
    end
    req_valid_i = '0;
    repeat (10) @(negedge clk);
    check("rstmid_inflight_before", 64'(inflight_o), 64'd5);
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rstmid_inflight",  64'(inflight_o), 64'd0);
    check("rstmid_div_a",     64'(div_dividend_o), 64'd0);
    check("rstmid_rsp_q",     64'(rsp_quotient_o), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base  = rsp_seen;
    repeat (2*LAT) @(negedge clk);
    check("rstmid_no_rsp", 64'(rsp_seen - base), 64'd0);

    // ---- random stress against a round-robin and arithmetic model
    mptr = 0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0]    v;
      logic [3:0]    g;
      logic          en;
      int            gi;
      logic [AW-1:0] a [4];
      logic [BW-1:0] b [4];
      v  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) begin
        int sel;
        a[i] = AW'({$urandom(), $urandom()});
        sel  = $urandom_range(0, 7);
        b[i] = (sel == 0) ? '0 : (sel == 1) ? BW'($urandom_range(1, 15)) : BW'($urandom());
        set_req(i, a[i], b[i]);
      end
      clken       = en;
      req_valid_i = v;
      g  = '0;
      gi = 0;
      if (en) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (mptr + k) % 4;
          if (g == '0 && v[idx]) begin
            g[idx] = 1'b1;
            gi     = idx;
          end
        end
      end
      #1 check("rand_grant", 64'(req_ready_o), 64'(g));
      if (g != '0) begin
        exp_q.push_back(mk_exp(gi, a[gi], b[gi]));
        mptr = (gi + 1) % 4;
      end
      @(negedge clk);
    end
    req_valid_i = '0;
    clken       = 1'b1;
    drain("rand_drain");
    check("rand_inflight_zero", 64'(inflight_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
